// File: rtl/pcap_pkg.sv
// Shared types for the pcap capture blocks: arbiter FSM state and default stream widths.
// No logic; imported by the arbiter and its testbench.
package pcap_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   localparam int PCAP_AXIS_WIDTH = 64;
   localparam int PCAP_STRB_W     = PCAP_AXIS_WIDTH / 8;

endpackage

// File: rtl/pcap_port_arbiter_rr_pick.sv
// Round-robin picker: first requester after last_i, wrapping; purely combinational.
// Zero latency, no flow control of its own.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] last_i,
   output logic [ID_W-1:0] grant_o,
   output logic            any_req_o
);

   int idx;

   // Walk from the farthest candidate back to the nearest so the nearest wins.
   always_comb begin
      grant_o = '0;
      idx     = 0;
      for (int i = N; i >= 1; i--) begin
         idx = (int'(last_i) + i) % N;
         for (int j = 0; j < N; j++) begin
            if (j == idx && req_i[j]) grant_o = ID_W'(j);
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/pcap_port_arbiter.sv
// Packet-locked round-robin merge of N AXI-Stream ports; 1-cycle arbitration, 0-cycle data path.
// m_tready passes straight to the granted port only; others see s_tready=0.
module pcap_port_arbiter
   import pcap_pkg::*;
#(
   parameter int N_PORTS    = 4,
   parameter int AXIS_WIDTH = PCAP_AXIS_WIDTH,
   parameter int ID_W       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_PORTS*AXIS_WIDTH-1:0] s_tdata,
   input  logic [N_PORTS*AXIS_WIDTH/8-1:0] s_tstrb,
   input  logic [N_PORTS-1:0]            s_tvalid,
   input  logic [N_PORTS-1:0]            s_tlast,
   output logic [N_PORTS-1:0]            s_tready,
   input  logic [N_PORTS-1:0]            s_eos,
   output logic [AXIS_WIDTH-1:0]         m_tdata,
   output logic [AXIS_WIDTH/8-1:0]       m_tstrb,
   output logic                          m_tvalid,
   output logic                          m_tlast,
   output logic [ID_W-1:0]               m_tid,
   input  logic                          m_tready,
   output logic                          m_eos,
   output logic [N_PORTS*CNT_W-1:0]      pkt_cnt
);

   localparam int STRB_W = AXIS_WIDTH / 8;

   arb_state_t               state_q, state_d;
   logic [ID_W-1:0]          grant_q, grant_d;   // also serves as last_grant
   logic                     eos_q, eos_d;
   logic [N_PORTS*CNT_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0]          pick;
   logic                     any_req;

   rr_pick #(.N(N_PORTS), .ID_W(ID_W)) u_pick (
      .req_i     (s_tvalid),
      .last_i    (grant_q),
      .grant_o   (pick),
      .any_req_o (any_req)
   );

   always_comb begin
      m_tdata  = '0;
      m_tstrb  = '0;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      m_tid    = '0;
      s_tready = '0;
      if (state_q == ARB_BUSY) begin
         m_tid = grant_q;
         for (int p = 0; p < N_PORTS; p++) begin
            if (grant_q == ID_W'(p)) begin
               m_tdata     = s_tdata[p*AXIS_WIDTH +: AXIS_WIDTH];
               m_tstrb     = s_tstrb[p*STRB_W +: STRB_W];
               m_tvalid    = s_tvalid[p];
               m_tlast     = s_tlast[p];
               s_tready[p] = m_tready;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      eos_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (any_req) begin
               grant_d = pick;
               state_d = ARB_BUSY;
            end else if (&s_eos) begin
               eos_d   = 1'b1;
               state_d = ARB_DONE;
            end
         end
         ARB_BUSY: begin
            if (m_tvalid && m_tready && m_tlast) begin
               state_d = ARB_IDLE;
               for (int p = 0; p < N_PORTS; p++) begin
                  if (grant_q == ID_W'(p))
                     cnt_d[p*CNT_W +: CNT_W] = cnt_q[p*CNT_W +: CNT_W] + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         grant_q <= ID_W'(N_PORTS - 1);
         eos_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         eos_q   <= eos_d;
         cnt_q   <= cnt_d;
      end
   end

   assign m_eos   = eos_q;
   assign pkt_cnt = cnt_q;

endmodule
